// File: rtl/vm_cash_pkg.sv
// Shared constants and types for the vending machine cash front end.
// Default denominations, debounce depth and the BCD engine state encoding.
package vm_cash_pkg;

    localparam int DENOM_1   = 1;
    localparam int DENOM_5   = 5;
    localparam int DENOM_10  = 10;
    localparam int DENOM_20  = 20;
    localparam int DENOM_50  = 50;
    localparam int DENOM_100 = 100;

    localparam int DEB_CYC_DEF = 16;

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_SHIFT,
        BCD_DONE
    } bcd_state_e;

endpackage

// File: rtl/cash_debounce.sv
// One cash channel: 2-FF synchroniser, debounce counter and a one-cycle
// pulse on each rising edge of the debounced level.
module cash_debounce
    import vm_cash_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic          flip;

    // Last differing sample of a full stable run flips the level.
    assign flip = (sync2_q != level_q) && (cnt_q == CW'(DEB_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            rise_q  <= flip && sync2_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/cash_accumulator.sv
// Cash acceptor front end: debounced channels summed into a saturating
// credit register with deduct/clear, plus a sequential binary-to-BCD engine.
module cash_accumulator
    import vm_cash_pkg::*;
#(
    parameter int                        NUM_CH     = 6,
    parameter int                        AMT_W      = 10,
    parameter int                        DENOM_W    = 8,
    parameter logic [NUM_CH*DENOM_W-1:0] DENOMS     = {
        8'(DENOM_100), 8'(DENOM_50), 8'(DENOM_20),
        8'(DENOM_10),  8'(DENOM_5),  8'(DENOM_1)
    },
    parameter int                        MAX_AMOUNT = 999,
    parameter int                        DEB_CYC    = DEB_CYC_DEF,
    parameter int                        BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       cash_in,
    input  logic                    clear,
    input  logic                    deduct_valid,
    input  logic [AMT_W-1:0]        deduct_amt,
    output logic                    deduct_ready,
    output logic                    deduct_done,
    output logic                    deduct_ok,
    output logic [AMT_W-1:0]        amount,
    output logic [NUM_CH-1:0]       reject,
    output logic [4*BCD_DIGITS-1:0] currency_bcd,
    output logic                    bcd_valid,
    output logic [NUM_CH-1:0]       cash_led
);

    localparam int SUM_W = AMT_W + 1;
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int IT_W  = $clog2(AMT_W + 1);

    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] ev;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cash_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (cash_in[i]),
            .level_o (lvl[i]),
            .rise_o  (ev[i])
        );
    end

    logic [AMT_W-1:0]  amount_q, amount_d;
    logic [NUM_CH-1:0] reject_q, reject_d;
    logic              done_q;
    logic              ok_q;

    logic [SUM_W-1:0]  ins;
    logic [SUM_W-1:0]  base;
    logic [SUM_W-1:0]  total;
    logic              tx;
    logic              ok;

    always_comb begin
        ins = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ev[i]) begin
                ins = ins + SUM_W'(DENOMS[i*DENOM_W +: DENOM_W]);
            end
        end
        tx    = deduct_valid && !clear;
        ok    = tx && (deduct_amt <= amount_q);
        base  = ok ? SUM_W'(amount_q - deduct_amt) : SUM_W'(amount_q);
        total = base + ins;
        amount_d = amount_q;
        reject_d = '0;
        if (clear) begin
            amount_d = '0;
            reject_d = ev;
        end else if (total <= SUM_W'(MAX_AMOUNT)) begin
            amount_d = total[AMT_W-1:0];
        end else begin
            // Whole cycle's insertions refused together on overflow.
            amount_d = base[AMT_W-1:0];
            reject_d = ev;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amount_q <= '0;
            reject_q <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            amount_q <= amount_d;
            reject_q <= reject_d;
            done_q   <= tx;
            ok_q     <= ok;
        end
    end

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    bcd_state_e       state_q;
    logic [AMT_W-1:0] snap_q;
    logic [AMT_W-1:0] bin_q;
    logic [BCD_W-1:0] work_q;
    logic [BCD_W-1:0] bcd_q;
    logic [IT_W-1:0]  it_q;
    logic             bcd_valid_q;
    logic [BCD_W-1:0] adj;

    assign adj = add3(work_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BCD_IDLE;
            snap_q      <= '0;
            bin_q       <= '0;
            work_q      <= '0;
            bcd_q       <= '0;
            it_q        <= '0;
            bcd_valid_q <= 1'b1;
        end else begin
            case (state_q)
                BCD_IDLE: begin
                    if (amount_q != snap_q) begin
                        snap_q      <= amount_q;
                        bin_q       <= amount_q;
                        work_q      <= '0;
                        it_q        <= '0;
                        bcd_valid_q <= 1'b0;
                        state_q     <= BCD_SHIFT;
                    end
                end
                BCD_SHIFT: begin
                    {work_q, bin_q} <= {adj, bin_q} << 1;
                    it_q <= it_q + 1'b1;
                    if (it_q == IT_W'(AMT_W - 1)) begin
                        state_q <= BCD_DONE;
                    end
                end
                BCD_DONE: begin
                    // A stale snapshot leaves valid low; IDLE reconverts.
                    bcd_q       <= work_q;
                    bcd_valid_q <= (snap_q == amount_q);
                    state_q     <= BCD_IDLE;
                end
                default: state_q <= BCD_IDLE;
            endcase
        end
    end

    assign deduct_ready = !clear;
    assign deduct_done  = done_q;
    assign deduct_ok    = ok_q;
    assign amount       = amount_q;
    assign reject       = reject_q;
    assign currency_bcd = bcd_q;
    assign bcd_valid    = bcd_valid_q;
    assign cash_led     = lvl;

endmodule

// File: tb/tb_cash_accumulator.sv
// Self-checking bench for cash_accumulator: vector table of insertions,
// scoreboard queues for reject and deduct results, hand-written corner cases.
module tb_cash_accumulator;

    logic        clk;
    logic        rst;
    logic [5:0]  cash_in;
    logic        clear;
    logic        deduct_valid;
    logic [9:0]  deduct_amt;
    logic        deduct_ready;
    logic        deduct_done;
    logic        deduct_ok;
    logic [9:0]  amount;
    logic [5:0]  reject;
    logic [15:0] currency_bcd;
    logic        bcd_valid;
    logic [5:0]  cash_led;

    cash_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .cash_in      (cash_in),
        .clear        (clear),
        .deduct_valid (deduct_valid),
        .deduct_amt   (deduct_amt),
        .deduct_ready (deduct_ready),
        .deduct_done  (deduct_done),
        .deduct_ok    (deduct_ok),
        .amount       (amount),
        .reject       (reject),
        .currency_bcd (currency_bcd),
        .bcd_valid    (bcd_valid),
        .cash_led     (cash_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] mask;
        int         len;
        int         amt;
        logic [5:0] rej;
        logic [5:0] led;
    } vec_t;

    typedef struct {
        logic ok;
        int   amt;
    } dexp_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_amt  = 0;
    logic [5:0] rq[$];
    dexp_t      dq[$];
    vec_t       vecs[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (reject != 6'b0) begin
                if (rq.size() == 0) chk("reject_unexpected", 32'(reject), 0);
                else chk("reject", 32'(reject), 32'(rq.pop_front()));
            end
            if (deduct_done) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", 32'(deduct_done), 0);
                end else begin
                    dexp_t d;
                    d = dq.pop_front();
                    chk("deduct_ok", 32'(deduct_ok), 32'(d.ok));
                    chk("deduct_amount", 32'(amount), 32'(d.amt));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int prev;
        prev = exp_amt;
        if (v.rej != 6'b0) rq.push_back(v.rej);
        for (int k = 0; k <= v.len + 24; k++) begin
            cash_in = (k < v.len) ? v.mask : 6'b0;
            if (k == 18) chk("amount_before", 32'(amount), 32'(prev));
            if (k == 19) begin
                chk("amount", 32'(amount), 32'(v.amt));
                chk("cash_led", 32'(cash_led), 32'(v.led));
            end
            if (k == 30) chk("bcd_busy", 32'(bcd_valid), 32'(v.amt == prev));
            if (k == 31) begin
                chk("currency_bcd", 32'(currency_bcd), 32'(to_bcd(v.amt)));
                chk("bcd_valid", 32'(bcd_valid), 1);
            end
            @(negedge clk);
        end
        exp_amt = v.amt;
    endtask

    task automatic deduct(input int amt, input logic exp_ok, input int exp_a);
        chk("deduct_ready", 32'(deduct_ready), 1);
        deduct_valid = 1'b1;
        deduct_amt   = 10'(amt);
        dq.push_back('{exp_ok, exp_a});
        @(negedge clk);
        deduct_valid = 1'b0;
        @(negedge clk);
        chk("done_single", 32'(deduct_done), 0);
        exp_amt = exp_a;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{6'b100000, 20, 100, 6'b000000, 6'b100000};
        vecs[1]  = '{6'b000001, 10, 100, 6'b000000, 6'b000000};
        vecs[2]  = '{6'b011001, 20, 171, 6'b000000, 6'b011001};
        vecs[3]  = '{6'b111111, 20, 357, 6'b000000, 6'b111111};
        vecs[4]  = '{6'b111111, 20, 543, 6'b000000, 6'b111111};
        vecs[5]  = '{6'b111111, 20, 729, 6'b000000, 6'b111111};
        vecs[6]  = '{6'b111111, 20, 915, 6'b000000, 6'b111111};
        vecs[7]  = '{6'b001110, 20, 950, 6'b000000, 6'b001110};
        vecs[8]  = '{6'b010100, 20, 950, 6'b010100, 6'b010100};
        vecs[9]  = '{6'b001000, 20, 970, 6'b000000, 6'b001000};
        vecs[10] = '{6'b001011, 20, 996, 6'b000000, 6'b001011};
        vecs[11] = '{6'b000001, 18, 997, 6'b000000, 6'b000001};
        vecs[12] = '{6'b000001, 18, 998, 6'b000000, 6'b000001};
        vecs[13] = '{6'b000001, 18, 999, 6'b000000, 6'b000001};
        vecs[14] = '{6'b000001, 18, 999, 6'b000001, 6'b000001};

        rst          = 1'b0;
        cash_in      = '0;
        clear        = 1'b0;
        deduct_valid = 1'b0;
        deduct_amt   = '0;
        repeat (3) @(negedge clk);
        chk("rst_amount", 32'(amount), 0);
        chk("rst_bcd", 32'(currency_bcd), 0);
        chk("rst_bcd_valid", 32'(bcd_valid), 1);
        chk("rst_reject", 32'(reject), 0);
        chk("rst_done", 32'(deduct_done), 0);
        chk("rst_ok", 32'(deduct_ok), 0);
        chk("rst_led", 32'(cash_led), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_amount", 32'(amount), 0);
        chk("idle_ready", 32'(deduct_ready), 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        clear = 1'b1;
        #1;
        chk("clear_ready", 32'(deduct_ready), 0);
        @(negedge clk);
        clear = 1'b0;
        chk("clear_amount", 32'(amount), 0);
        exp_amt = 0;
        run_vec('{6'b101000, 20, 120, 6'b000000, 6'b101000});

        deduct(85, 1'b1, 35);
        deduct(40, 1'b0, 35);
        chk("deduct_fail_amount", 32'(amount), 35);

        for (int k = 0; k <= 60; k++) begin
            cash_in = (k < 20) ? 6'b000010 : 6'b0;
            if (k == 18) begin
                deduct_valid = 1'b1;
                deduct_amt   = 10'd30;
                dq.push_back('{1'b1, 10});
            end
            if (k == 19) begin
                deduct_valid = 1'b0;
                chk("mixed_amount", 32'(amount), 10);
            end
            if (k == 24) begin
                chk("held_bcd", 32'(currency_bcd), 32'(to_bcd(35)));
                chk("held_valid", 32'(bcd_valid), 0);
                clear = 1'b1;
                #1;
                chk("clear_ready_busy", 32'(deduct_ready), 0);
            end
            if (k == 25) begin
                clear = 1'b0;
                chk("clear_busy_amount", 32'(amount), 0);
            end
            if (k == 60) begin
                chk("final_bcd", 32'(currency_bcd), 0);
                chk("final_valid", 32'(bcd_valid), 1);
                chk("final_amount", 32'(amount), 0);
            end
            @(negedge clk);
        end

        chk("reject_queue_empty", 32'(rq.size()), 0);
        chk("deduct_queue_empty", 32'(dq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
